// File: rtl/sevenseg_scan_if.sv
// Display bus for sevenseg_scan: the shadow-load inputs and the scanned
// segment/digit outputs, sized by the number of digits.
interface sevenseg_scan_if #(
  parameter int DIGITS = 4
) ();
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank;
  logic                load;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic                frame_tick;

  // Producer of display data; observes the scanned outputs.
  modport master (
    output value, dp_in, blank, load,
    input  seg, dp, an, frame_tick
  );

  // The scanner: takes display data, drives the panel.
  modport slave (
    input  value, dp_in, blank, load,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment scanner.
// Display data is captured into shadow registers on load and shown one digit
// per slot of CLK_DIV clocks; the first clock of every slot is dead time with
// all digits off to avoid ghosting. seg/dp/an/frame_tick are registered.
// Optional feature: define SEVENSEG_LZB_EN for leading-zero blanking.
module sevenseg_scan #(
  parameter int DIGITS        = 4,
  parameter int CLK_DIV       = 50000,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic           clk,
  input  logic           rst,
  sevenseg_scan_if.slave bus
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [6:0]        SEG_OFF = 7'b1111111;

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0011000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] val_sh_q, val_sh_d;
  logic [DIGITS-1:0]   dpm_sh_q, dpm_sh_d;
  logic [DIGITS-1:0]   blk_sh_q, blk_sh_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_tick_q, frame_tick_d;

  logic                slot_end_s;
  logic [DIGITS-1:0]   blank_eff_s;
  logic [DIGITS-1:0]   onehot_s;
  logic [3:0]          nibble_s;
  logic                dp_req_s;
  logic                dig_blank_s;
  logic                dark_s;

`ifdef SEVENSEG_LZB_EN
  logic [DIGITS-1:0]   lzb_s;
  logic                zero_above_s;

  // Leading-zero mask: digit i>0 goes dark while it and all higher nibbles are zero.
  always_comb begin
    lzb_s        = '0;
    zero_above_s = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above_s = zero_above_s & (val_sh_q[4*i +: 4] == 4'h0);
      lzb_s[i]     = zero_above_s;
    end
  end

  assign blank_eff_s = blk_sh_q | lzb_s;
`else
  assign blank_eff_s = blk_sh_q;
`endif

  // Prescaler, digit index, frame pulse and shadow capture.
  always_comb begin
    slot_end_s   = (cnt_q == CNT_MAX);
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    frame_tick_d = 1'b0;
    if (slot_end_s) begin
      cnt_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d        = '0;
        frame_tick_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (bus.load) begin
      val_sh_d = bus.value;
      dpm_sh_d = bus.dp_in;
      blk_sh_d = bus.blank;
    end else begin
      val_sh_d = val_sh_q;
      dpm_sh_d = dpm_sh_q;
      blk_sh_d = blk_sh_q;
    end
  end

  // Select the current digit's data and form the next panel outputs.
  always_comb begin
    onehot_s    = '0;
    nibble_s    = 4'h0;
    dp_req_s    = 1'b0;
    dig_blank_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        onehot_s[i] = 1'b1;
        nibble_s    = val_sh_q[4*i +: 4];
        dp_req_s    = dpm_sh_q[i];
        dig_blank_s = blank_eff_s[i];
      end else begin
        onehot_s[i] = 1'b0;
      end
    end
    dark_s = (cnt_q == '0) || dig_blank_s;
    if (dark_s) begin
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      an_d  = AN_OFF;
    end else begin
      seg_d = hex_to_seg(nibble_s);
      dp_d  = ~dp_req_s;
      if (AN_ACTIVE_LOW != 0) begin
        an_d = ~onehot_s;
      end else begin
        an_d = onehot_s;
      end
    end
  end

  // State and output registers; reset darkens the panel immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      val_sh_q     <= '0;
      dpm_sh_q     <= '0;
      blk_sh_q     <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      an_q         <= AN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      val_sh_q     <= val_sh_d;
      dpm_sh_q     <= dpm_sh_d;
      blk_sh_q     <= blk_sh_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan (DIGITS=4, CLK_DIV=4, active-low an) plus
// a single-digit, high-active-an instance (DIGITS=1, CLK_DIV=3).
module tb_sevenseg_scan;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sevenseg_scan_if #(.DIGITS(4)) bus ();
  sevenseg_scan_if #(.DIGITS(1)) bus1 ();

  sevenseg_scan #(.DIGITS(4), .CLK_DIV(4), .AN_ACTIVE_LOW(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sevenseg_scan #(.DIGITS(1), .CLK_DIV(3), .AN_ACTIVE_LOW(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // {an, seg, dp, frame_tick}
  wire [12:0] obs  = {bus.an, bus.seg, bus.dp, bus.frame_tick};
  wire [9:0]  obs1 = {bus1.an, bus1.seg, bus1.dp, bus1.frame_tick};

  localparam logic [12:0] DARK = {4'b1111, 7'b1111111, 1'b1, 1'b0};
  localparam logic [6:0]  G0   = 7'b1000000;
  localparam logic [27:0] ZEROS = {G0, G0, G0, G0};

  // Expected outputs n cycles after reset release for a steady shadow.
  // segs = {d3,d2,d1,d0}; dps/shown bit i = digit i.
  function automatic logic [12:0] exp_vec(input int n, input logic [27:0] segs,
                                          input logic [3:0] dps, input logic [3:0] shown);
    int         slot;
    int         phase;
    logic       ft;
    logic [3:0] an_e;
    slot  = (n / 4) % 4;
    phase = n % 4;
    ft    = ((n % 16) == 15);
    an_e  = 4'b1111;
    if (phase == 0 || !shown[slot]) begin
      return {4'b1111, 7'b1111111, 1'b1, ft};
    end else begin
      an_e[slot] = 1'b0;
      return {an_e, segs[slot*7 +: 7], ~dps[slot], ft};
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset both DUTs with the given load request pending at release.
  task automatic do_reset(input logic [15:0] v, input logic [3:0] dpi,
                          input logic [3:0] blk, input logic ld);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.value = v;
    bus.dp_in = dpi;
    bus.blank = blk;
    bus.load  = ld;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    rst = 1'b1;
    bus.value = 16'h0; bus.dp_in = 4'h0; bus.blank = 4'h0; bus.load = 1'b0;
    bus1.value = 4'h0; bus1.dp_in = 1'b0; bus1.blank = 1'b0; bus1.load = 1'b0;
    #12;
    vectors++;
    if (obs !== DARK) begin
      miscompares++;
      $display("FAIL reset_state: an/seg/dp/ft got %b want %b", obs, DARK);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 32; n++) begin
      step();
      e = exp_vec(n, ZEROS, 4'h0, 4'hF);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL scan_after_reset cyc %0d: got %b want %b", n, obs, e);
      end
    end
  endtask

  task automatic test_decode_12ef();
    logic [12:0] e;
    do_reset(16'h12EF, 4'h0, 4'h0, 1'b1);
    for (int n = 0; n < 16; n++) begin
      step();
      if (n == 0) bus.load = 1'b0;
      e = exp_vec(n, {7'b1111001, 7'b0100100, 7'b0000110, 7'b0001110}, 4'h0, 4'hF);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL decode_12EF cyc %0d: got %b want %b", n, obs, e);
      end
    end
  endtask

  // Reload at each frame boundary with no gap; covers every glyph.
  task automatic test_back_to_back();
    logic [15:0] vals [4];
    logic [27:0] segs [4];
    logic [12:0] e;
    vals[0] = 16'h3210; segs[0] = {7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000};
    vals[1] = 16'h7654; segs[1] = {7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001};
    vals[2] = 16'hBA98; segs[2] = {7'b0000011, 7'b0001000, 7'b0011000, 7'b0000000};
    vals[3] = 16'hFEDC; segs[3] = {7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110};
    for (int k = 0; k < 4; k++) begin
      bus.value = vals[k];
      bus.load  = 1'b1;
      for (int n = 0; n < 16; n++) begin
        step();
        if (n == 0) bus.load = 1'b0;
        e = exp_vec(n, segs[k], 4'h0, 4'hF);
        vectors++;
        if (obs !== e) begin
          miscompares++;
          $display("FAIL back_to_back %h cyc %0d: got %b want %b", vals[k], n, obs, e);
        end
      end
    end
  endtask

  task automatic test_dp_blank();
    logic [12:0] e;
    do_reset(16'h0000, 4'b0100, 4'b0001, 1'b1);
    for (int n = 0; n < 16; n++) begin
      step();
      if (n == 0) bus.load = 1'b0;
      e = exp_vec(n, ZEROS, 4'b0100, 4'b1110);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL dp_blank cyc %0d: got %b want %b", n, obs, e);
      end
    end
  endtask

  task automatic test_lzb();
    logic [12:0] e;
    logic [3:0]  shown;
`ifdef SEVENSEG_LZB_EN
    shown = 4'b0011;
`else
    shown = 4'b1111;
`endif
    do_reset(16'h0050, 4'h0, 4'h0, 1'b1);
    for (int n = 0; n < 16; n++) begin
      step();
      if (n == 0) bus.load = 1'b0;
      e = exp_vec(n, {G0, G0, 7'b0010010, G0}, 4'h0, shown);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL lzb_0050 cyc %0d: got %b want %b", n, obs, e);
      end
    end
  endtask

  // Load while digit 1 is lit: new glyph one output cycle later, slot unchanged.
  task automatic test_midslot_load();
    logic [12:0] e;
    do_reset(16'h0000, 4'h0, 4'h0, 1'b1);
    for (int n = 0; n < 16; n++) begin
      step();
      if (n == 0 || n == 6) bus.load = 1'b0;
      if (n >= 7) e = exp_vec(n, {G0, G0, 7'b0011000, G0}, 4'h0, 4'hF);
      else        e = exp_vec(n, ZEROS, 4'h0, 4'hF);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL midslot_load cyc %0d: got %b want %b", n, obs, e);
      end
      if (n == 5) begin
        bus.value = 16'h0090;
        bus.load  = 1'b1;
      end
    end
  endtask

  task automatic test_reset_midslot();
    logic [12:0] e;
    do_reset(16'h12EF, 4'b1111, 4'h0, 1'b1);
    for (int n = 0; n < 10; n++) begin
      step();
      if (n == 0) bus.load = 1'b0;
      e = exp_vec(n, {7'b1111001, 7'b0100100, 7'b0000110, 7'b0001110}, 4'b1111, 4'hF);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL pre_reset_slot cyc %0d: got %b want %b", n, obs, e);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (obs !== DARK) begin
      miscompares++;
      $display("FAIL async_reset_dark: got %b want %b", obs, DARK);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 16; n++) begin
      step();
      e = exp_vec(n, ZEROS, 4'h0, 4'hF);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL post_reset_restart cyc %0d: got %b want %b", n, obs, e);
      end
    end
  endtask

  // One digit, CLK_DIV=3, high-active an: index fixed, frame_tick every slot.
  task automatic test_single_digit();
    logic [9:0] e;
    @(posedge clk);
    #1;
    rst        = 1'b1;
    bus1.value = 4'hA;
    bus1.dp_in = 1'b1;
    bus1.load  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 9; n++) begin
      step();
      if (n == 0) bus1.load = 1'b0;
      if ((n % 3) == 0) e = {1'b0, 7'b1111111, 1'b1, 1'b0};
      else              e = {1'b1, 7'b0001000, 1'b0, ((n % 3) == 2)};
      vectors++;
      if (obs1 !== e) begin
        miscompares++;
        $display("FAIL single_digit cyc %0d: an/seg/dp/ft got %b want %b", n, obs1, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode_12ef();
    test_back_to_back();
    test_dp_blank();
    test_lzb();
    test_midslot_load();
    test_reset_midslot();
    test_single_digit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
